uart_boot_loader: RTL and testbench

//   Serial program loader feeding the CPU top's UartData/UartAddress/UartOver inputs.

---
 rtl/uart_boot_loader_if.sv | 11 +
 rtl/uart_boot_loader.sv | 266 ++++++++++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_boot_loader_if.sv
// Memory write port from the UART boot loader to the CPU top.
// The loader drives it through the master modport; the consumer uses the slave modport.
interface uart_boot_loader_if;
  logic [31:0] UartData;
  logic [31:0] UartAddress;
  logic        UartWrite;
  logic        UartOver;

  modport master (output UartData, output UartAddress, output UartWrite, output UartOver);
  modport slave  (input  UartData, input  UartAddress, input  UartWrite, input  UartOver);
endinterface

// File: rtl/uart_boot_loader.sv
// UART 8N1 receiver plus length-prefixed word loader that drives sequential memory writes.
// Optional trailing XOR checksum byte is enabled with macro UART_LOADER_CHECKSUM_EN.
module uart_boot_loader #(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          MAX_WORDS    = 16384
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                uart_rx,
  uart_boot_loader_if.master  mem,
  output logic                frame_err,
  output logic                load_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
`ifdef UART_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {S_LEN, S_DATA, S_CHK, S_DONE} ld_state_e;
`else
  typedef enum logic [1:0] {S_LEN, S_DATA, S_DONE} ld_state_e;
`endif

  logic            rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            rx_valid_q, rx_valid_d;
  logic            ferr_q, ferr_d;

  ld_state_e       state_q, state_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [31:0]     asm_q, asm_d, asm_s;
  logic [31:0]     remaining_q, remaining_d;
  logic [29:0]     word_idx_q, word_idx_d;
  logic [31:0]     data_q, data_d;
  logic [31:0]     addr_q, addr_d;
  logic            write_q, write_d;
  logic            over_q, over_d;
  logic            lerr_q, lerr_d;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]      csum_q, csum_d;
`endif

  // Line synchronizer; rx_prev_q gives the falling-edge reference
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= uart_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // Receiver bit timing: half a bit to the start centre, then full bits
  always_comb begin
    rx_state_d = rx_state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    rx_valid_d = 1'b0;
    ferr_d     = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = RX_START;
          cnt_d      = '0;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d      = '0;
          bit_d      = 3'd0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s2_q, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d      = '0;
          rx_state_d = RX_IDLE;
          if (rx_s2_q) begin
            rx_valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Receiver state register
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      cnt_q      <= '0;
      bit_q      <= 3'd0;
      shift_q    <= 8'd0;
      rx_valid_q <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      rx_valid_q <= rx_valid_d;
      ferr_q     <= ferr_d;
    end
  end

  // Little-endian word assembly: byte k lands in bits [8k+7:8k]
  always_comb begin
    asm_s = asm_q;
    asm_s[{byte_idx_q, 3'b000} +: 8] = shift_q;
  end

  // Loader FSM: length word, data words, optional checksum, done
  always_comb begin
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    asm_d       = asm_q;
    remaining_d = remaining_q;
    word_idx_d  = word_idx_q;
    data_d      = data_q;
    addr_d      = addr_q;
    write_d     = 1'b0;
    over_d      = (state_q == S_DONE);
    lerr_d      = lerr_q;
`ifdef UART_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    if (rx_valid_q && (state_q != S_DONE)) begin
      byte_idx_d = byte_idx_q + 2'd1;
      asm_d      = asm_s;
`ifdef UART_LOADER_CHECKSUM_EN
      csum_d     = csum_q ^ shift_q;
`endif
      case (state_q)
        S_LEN: begin
          if (byte_idx_q != 2'd3) begin
            state_d = S_LEN;
          end else if (asm_s == 32'd0) begin
            lerr_d = 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_DONE;
`endif
          end else if (asm_s > 32'(MAX_WORDS)) begin
            lerr_d = 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
            csum_d = 8'd0;
`endif
          end else begin
            lerr_d      = 1'b0;
            remaining_d = asm_s;
            state_d     = S_DATA;
          end
        end
        S_DATA: begin
          if (byte_idx_q == 2'd3) begin
            write_d     = 1'b1;
            data_d      = asm_s;
            addr_d      = BASE_ADDR + {word_idx_q, 2'b00};
            word_idx_d  = word_idx_q + 30'd1;
            remaining_d = remaining_q - 32'd1;
            if (remaining_q == 32'd1) begin
`ifdef UART_LOADER_CHECKSUM_EN
              state_d = S_CHK;
`else
              state_d = S_DONE;
`endif
            end else begin
              state_d = S_DATA;
            end
          end else begin
            state_d = S_DATA;
          end
        end
`ifdef UART_LOADER_CHECKSUM_EN
        S_CHK: begin
          byte_idx_d = 2'd0;
          if (shift_q == csum_q) begin
            state_d = S_DONE;
          end else begin
            lerr_d     = 1'b1;
            state_d    = S_LEN;
            word_idx_d = 30'd0;
            csum_d     = 8'd0;
          end
        end
`endif
        default: state_d = state_q;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Loader state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LEN;
      byte_idx_q  <= 2'd0;
      asm_q       <= 32'd0;
      remaining_q <= 32'd0;
      word_idx_q  <= 30'd0;
      data_q      <= 32'd0;
      addr_q      <= BASE_ADDR;
      write_q     <= 1'b0;
      over_q      <= 1'b0;
      lerr_q      <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
      csum_q      <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      asm_q       <= asm_d;
      remaining_q <= remaining_d;
      word_idx_q  <= word_idx_d;
      data_q      <= data_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      over_q      <= over_d;
      lerr_q      <= lerr_d;
`ifdef UART_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign mem.UartData    = data_q;
  assign mem.UartAddress = addr_q;
  assign mem.UartWrite   = write_q;
  assign mem.UartOver    = over_q;
  assign frame_err       = ferr_q;
  assign load_err        = lerr_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: frames are serialised bit by bit, expected writes are
// queued from a byte-level model, and a negedge monitor pops and compares each UartWrite.
module tb_uart_boot_loader;
  localparam int CPB  = 8;
  localparam int MAXW = 16384;

  logic clk = 1'b0;
  logic rst;
  logic uart_rx;
  logic frame_err;
  logic load_err;

  uart_boot_loader_if bus ();

  uart_boot_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(32'h0), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .mem(bus.master),
    .frame_err(frame_err), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          last_wr_cyc = -100;
  int          ferr_cnt = 0;
  logic [63:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, want);
    end
  endtask

  // Monitor: every write must match the head of the expectation queue
  always @(negedge clk) begin : monitor
    logic [63:0] e;
    if (bus.UartWrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %h data %h, want no write", bus.UartAddress, bus.UartData);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", bus.UartAddress, e[63:32]);
        chk("wr_data", bus.UartData, e[31:0]);
      end
      chk("write_over_exclusive", {31'd0, bus.UartOver}, 32'd0);
      last_wr_cyc = cyc;
    end
    if (frame_err === 1'b1) ferr_cnt++;
  end

  task automatic line(input logic v, input int n);
    uart_rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    line(1'b0, CPB);
    for (int i = 0; i < 8; i++) line(b[i], CPB);
    line(stop, CPB);
    if (!stop) line(1'b1, 2 * CPB);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    ferr_cnt = 0;
    last_wr_cyc = -100;
  endtask

  task automatic check_reset();
    @(negedge clk);
    chk("rst_data", bus.UartData, 32'd0);
    chk("rst_addr", bus.UartAddress, 32'd0);
    chk("rst_write", {31'd0, bus.UartWrite}, 32'd0);
    chk("rst_over", {31'd0, bus.UartOver}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_load_err", {31'd0, load_err}, 32'd0);
  endtask

  // Model: word i = d[4i] + d[4i+1]*2^8 + d[4i+2]*2^16 + d[4i+3]*2^24 at byte address 4*i
  task automatic send_frame(input int n, input logic [7:0] d[$]);
    logic [31:0] w;
    logic [7:0]  len_b [4];
`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0]  ck;
`endif
    for (int i = 0; i < n; i++) begin
      w = 32'(d[4*i]) + 32'(d[4*i+1]) * 256 + 32'(d[4*i+2]) * 65536 + 32'(d[4*i+3]) * 16777216;
      exp_q.push_back({32'(4 * i), w});
    end
    for (int k = 0; k < 4; k++) len_b[k] = 8'((n >> (8 * k)) % 256);
    for (int k = 0; k < 4; k++) send_byte(len_b[k], 1'b1);
    for (int k = 0; k < 4 * n; k++) send_byte(d[k], 1'b1);
`ifdef UART_LOADER_CHECKSUM_EN
    ck = 8'd0;
    for (int k = 0; k < 4; k++) ck = ck ^ len_b[k];
    for (int k = 0; k < 4 * n; k++) ck = ck ^ d[k];
    send_byte(ck, 1'b1);
`endif
  endtask

  // Bounded wait for UartOver, then completion checks
  task automatic finish_frame(input string nm, input logic had_data);
    int k = 0;
    while (k < 200 && bus.UartOver !== 1'b1) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_over"}, {31'd0, bus.UartOver}, 32'd1);
`ifndef UART_LOADER_CHECKSUM_EN
    if (had_data) chk({nm, "_over_after_write"}, 32'(cyc - last_wr_cyc), 32'd1);
`endif
    chk({nm, "_pending"}, 32'(exp_q.size()), 32'd0);
    chk({nm, "_load_err"}, {31'd0, load_err}, 32'd0);
  endtask

  initial begin
    logic [7:0] d[$];
    int         n;
    logic [31:0] hold_data;

    do_reset();
    check_reset();

    // Fixed two-word image
    d = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
    send_frame(2, d);
    finish_frame("two_words", 1'b1);
    chk("two_words_hold_addr", bus.UartAddress, 32'h4);
    chk("two_words_hold_data", bus.UartData, 32'hAABBCCDD);

    // Zero-length image
    do_reset();
    d.delete();
    send_frame(0, d);
    finish_frame("len_zero", 1'b0);

    // Bad stop bit then a good frame
    do_reset();
    send_byte(8'hA5, 1'b0);
    d.delete();
    for (int k = 0; k < 4; k++) d.push_back(8'($urandom));
    send_frame(1, d);
    finish_frame("after_ferr", 1'b1);
    chk("ferr_count", 32'(ferr_cnt), 32'd1);

    // Start-bit glitch then a good frame
    do_reset();
    line(1'b0, 3);
    line(1'b1, 2 * CPB);
    d.delete();
    for (int k = 0; k < 4; k++) d.push_back(8'($urandom));
    send_frame(1, d);
    finish_frame("after_glitch", 1'b1);
    chk("glitch_no_ferr", 32'(ferr_cnt), 32'd0);

    // Reset in the middle of the first data word
    do_reset();
    send_byte(8'h01, 1'b1);
    for (int k = 0; k < 3; k++) send_byte(8'h00, 1'b1);
    send_byte(8'h5A, 1'b1);
    send_byte(8'hC3, 1'b1);
    do_reset();
    check_reset();
    d.delete();
    for (int k = 0; k < 8; k++) d.push_back(8'($urandom));
    send_frame(2, d);
    finish_frame("after_midrst", 1'b1);

    // Oversized length
    do_reset();
    send_byte(8'h01, 1'b1);
    send_byte(8'h40, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (20) @(negedge clk);
    chk("oversize_load_err", {31'd0, load_err}, 32'd1);
    chk("oversize_over", {31'd0, bus.UartOver}, 32'd0);

`ifdef UART_LOADER_CHECKSUM_EN
    // Bad checksum then retry with the good one
    do_reset();
    exp_q.push_back({32'h0, 32'h01020304});
    d = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
    foreach (d[k]) send_byte(d[k], 1'b1);
    repeat (20) @(negedge clk);
    chk("bad_ck_load_err", {31'd0, load_err}, 32'd1);
    chk("bad_ck_over", {31'd0, bus.UartOver}, 32'd0);
    chk("bad_ck_pending", 32'(exp_q.size()), 32'd0);
    d = '{8'h04, 8'h03, 8'h02, 8'h01};
    send_frame(1, d);
    finish_frame("good_ck", 1'b1);
`endif

    // Random images, then a stray byte that must be ignored
    for (int t = 0; t < 6; t++) begin
      do_reset();
      n = $urandom_range(1, 5);
      d.delete();
      for (int k = 0; k < 4 * n; k++) d.push_back(8'($urandom));
      send_frame(n, d);
      finish_frame("random", 1'b1);
      hold_data = bus.UartData;
      send_byte(8'($urandom), 1'b1);
      repeat (5) @(negedge clk);
      chk("done_sticky_over", {31'd0, bus.UartOver}, 32'd1);
      chk("done_hold_addr", bus.UartAddress, 32'(4 * (n - 1)));
      chk("done_hold_data", bus.UartData, hold_data);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
